// File: rtl/attn_mem_pkg.sv
// Shared constants and state encoding for the attention-layer output/buffer memories.
package attn_mem_pkg;

   localparam int ATTN_DATA_WIDTH = 16;
   localparam int OUT_RAM_DEPTH   = 512;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_READY = 1'b1
   } mem_state_t;

   // Cycles from an accepted read request to valid_x/out_x.
   function automatic int read_latency(input int out_reg);
      return 1 + out_reg;
   endfunction

endpackage

// File: rtl/dpram_core.sv
// Bare true dual-port RAM array: two synchronous read-first ports, no reset.
module dpram_core
   import attn_mem_pkg::*;
#(
   parameter int DATA_WIDTH = ATTN_DATA_WIDTH,
   parameter int ADDR_WIDTH = $clog2(OUT_RAM_DEPTH)
) (
   input  logic                  clk,
   input  logic                  we_a,
   input  logic [ADDR_WIDTH-1:0] addr_a,
   input  logic [DATA_WIDTH-1:0] din_a,
   output logic [DATA_WIDTH-1:0] dout_a,
   input  logic                  we_b,
   input  logic [ADDR_WIDTH-1:0] addr_b,
   input  logic [DATA_WIDTH-1:0] din_b,
   output logic [DATA_WIDTH-1:0] dout_b
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // Reads return pre-write contents; the wrapper never enables both writes to one address.
   always_ff @(posedge clk) begin
      if (we_a) mem[addr_a] <= din_a;
      if (we_b) mem[addr_b] <= din_b;
      dout_a <= mem[addr_a];
      dout_b <= mem[addr_b];
   end

endmodule

// File: rtl/dpram_param.sv
// Parametrised dual-port RAM wrapper: post-reset clear sweep, write-write arbitration,
// read-valid pipeline and optional output register around dpram_core.
module dpram_param
   import attn_mem_pkg::*;
#(
   parameter int DATA_WIDTH     = ATTN_DATA_WIDTH,
   parameter int ADDR_WIDTH     = $clog2(OUT_RAM_DEPTH),
   parameter int OUT_REG        = 0,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [ADDR_WIDTH-1:0] address_a,
   input  logic [ADDR_WIDTH-1:0] address_b,
   input  logic                  wren_a,
   input  logic                  wren_b,
   input  logic                  rden_a,
   input  logic                  rden_b,
   input  logic [DATA_WIDTH-1:0] data_a,
   input  logic [DATA_WIDTH-1:0] data_b,
   output logic [DATA_WIDTH-1:0] out_a,
   output logic [DATA_WIDTH-1:0] out_b,
   output logic                  valid_a,
   output logic                  valid_b,
   output logic                  busy,
   output logic                  collision,
   output logic                  state_dbg
);

   localparam int LATENCY = read_latency(OUT_REG);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
   localparam mem_state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;

   mem_state_t            state, state_nxt;
   logic [ADDR_WIDTH-1:0] clr_cnt, clr_cnt_nxt;
   logic                  clr_we;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= RESET_STATE;
         clr_cnt <= '0;
      end else begin
         state   <= state_nxt;
         clr_cnt <= clr_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      clr_cnt_nxt = clr_cnt;
      clr_we      = 1'b0;
      case (state)
         ST_CLEAR: begin
            clr_we      = 1'b1;
            clr_cnt_nxt = clr_cnt + 1'b1;
            if (clr_cnt == LAST_ADDR) state_nxt = ST_READY;
         end
         default: ;
      endcase
   end

   assign busy      = (state == ST_CLEAR);
   assign state_dbg = state;

   logic ready;
   logic wr_a, wr_b_req, wr_b, col_hit;
   logic rd_a, rd_b;

   assign ready    = (state == ST_READY);
   assign wr_a     = ready & wren_a;
   assign wr_b_req = ready & wren_b;
   // Port A wins a same-address double write; B's write is dropped.
   assign col_hit  = wr_a & wr_b_req & (address_a == address_b);
   assign wr_b     = wr_b_req & ~col_hit;
   assign rd_a     = ready & rden_a & ~wren_a;
   assign rd_b     = ready & rden_b & ~wren_b;

   logic                  core_we_a;
   logic [ADDR_WIDTH-1:0] core_addr_a;
   logic [DATA_WIDTH-1:0] core_din_a;
   logic [DATA_WIDTH-1:0] dout_a, dout_b;

   // The clear sweep borrows port A while busy.
   assign core_we_a   = clr_we | wr_a;
   assign core_addr_a = busy ? clr_cnt : address_a;
   assign core_din_a  = busy ? '0 : data_a;

   dpram_core #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_core (
      .clk    (clk),
      .we_a   (core_we_a),
      .addr_a (core_addr_a),
      .din_a  (core_din_a),
      .dout_a (dout_a),
      .we_b   (wr_b),
      .addr_b (address_b),
      .din_b  (data_b),
      .dout_b (dout_b)
   );

   logic                  rd_q_a, rd_q_b;
   logic                  valid1_a, valid1_b;
   logic [DATA_WIDTH-1:0] out1_a, out1_b;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_q_a    <= 1'b0;
         rd_q_b    <= 1'b0;
         valid1_a  <= 1'b0;
         valid1_b  <= 1'b0;
         out1_a    <= '0;
         out1_b    <= '0;
         collision <= 1'b0;
      end else begin
         rd_q_a    <= rd_a;
         rd_q_b    <= rd_b;
         valid1_a  <= rd_q_a;
         valid1_b  <= rd_q_b;
         if (rd_q_a) out1_a <= dout_a;
         if (rd_q_b) out1_b <= dout_b;
         collision <= col_hit;
      end
   end

   if (LATENCY > 1) begin : g_out_reg
      logic [DATA_WIDTH-1:0] out2_a, out2_b;
      logic                  valid2_a, valid2_b;

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            valid2_a <= 1'b0;
            valid2_b <= 1'b0;
            out2_a   <= '0;
            out2_b   <= '0;
         end else begin
            valid2_a <= valid1_a;
            valid2_b <= valid1_b;
            if (valid1_a) out2_a <= out1_a;
            if (valid1_b) out2_b <= out1_b;
         end
      end

      assign out_a   = out2_a;
      assign out_b   = out2_b;
      assign valid_a = valid2_a;
      assign valid_b = valid2_b;
   end else begin : g_no_out_reg
      assign out_a   = out1_a;
      assign out_b   = out1_b;
      assign valid_a = valid1_a;
      assign valid_b = valid1_b;
   end

endmodule

// File: tb/tb_dpram_param.sv
// Bench for dpram_param: one instance with OUT_REG=0 and one with OUT_REG=1 share all inputs.
module tb_dpram_param;

   logic clk;
   logic reset;
   logic [8:0]  address_a, address_b;
   logic        wren_a, wren_b, rden_a, rden_b;
   logic [15:0] data_a, data_b;

   logic [15:0] out_a0, out_b0, out_a1, out_b1;
   logic        valid_a0, valid_b0, valid_a1, valid_b1;
   logic        busy0, busy1, col0, col1, st0, st1;

   dpram_param #(.DATA_WIDTH(16), .ADDR_WIDTH(9), .OUT_REG(0), .CLEAR_ON_RESET(1)) u_dut0 (
      .clk(clk), .reset(reset),
      .address_a(address_a), .address_b(address_b),
      .wren_a(wren_a), .wren_b(wren_b), .rden_a(rden_a), .rden_b(rden_b),
      .data_a(data_a), .data_b(data_b),
      .out_a(out_a0), .out_b(out_b0), .valid_a(valid_a0), .valid_b(valid_b0),
      .busy(busy0), .collision(col0), .state_dbg(st0)
   );

   dpram_param #(.DATA_WIDTH(16), .ADDR_WIDTH(9), .OUT_REG(1), .CLEAR_ON_RESET(1)) u_dut1 (
      .clk(clk), .reset(reset),
      .address_a(address_a), .address_b(address_b),
      .wren_a(wren_a), .wren_b(wren_b), .rden_a(rden_a), .rden_b(rden_b),
      .data_a(data_a), .data_b(data_b),
      .out_a(out_a1), .out_b(out_b1), .valid_a(valid_a1), .valid_b(valid_b1),
      .busy(busy1), .collision(col1), .state_dbg(st1)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: run did not complete in time");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard ----------------
   // Monitor index: 0 = dut0 A, 1 = dut0 B, 2 = dut1 A, 3 = dut1 B
   int errors = 0;
   int checks = 0;
   logic [15:0] exp_q[4][$];
   int          due_q[4][$];
   int          col_q[$];
   logic [15:0] model [512];

   logic        v_s [4];
   logic [15:0] o_s [4];
   assign v_s[0] = valid_a0;
   assign v_s[1] = valid_b0;
   assign v_s[2] = valid_a1;
   assign v_s[3] = valid_b1;
   assign o_s[0] = out_a0;
   assign o_s[1] = out_b0;
   assign o_s[2] = out_a1;
   assign o_s[3] = out_b1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   always @(negedge clk) begin
      for (int p = 0; p < 4; p++) begin
         if (due_q[p].size() > 0 && due_q[p][0] == cyc) begin
            chk($sformatf("valid_p%0d", p), {31'd0, v_s[p]}, 32'd1);
            chk($sformatf("data_p%0d", p), {16'd0, o_s[p]}, {16'd0, exp_q[p][0]});
            void'(exp_q[p].pop_front());
            void'(due_q[p].pop_front());
         end else begin
            chk($sformatf("idle_valid_p%0d", p), {31'd0, v_s[p]}, 32'd0);
         end
      end
      if (col_q.size() > 0 && col_q[0] == cyc) begin
         chk("collision_0", {31'd0, col0}, 32'd1);
         chk("collision_1", {31'd0, col1}, 32'd1);
         void'(col_q.pop_front());
      end else begin
         chk("no_collision_0", {31'd0, col0}, 32'd0);
         chk("no_collision_1", {31'd0, col1}, 32'd0);
      end
   end

   // ---------------- driver ----------------
   typedef struct {
      logic        wa;
      logic        ra;
      logic [8:0]  aa;
      logic [15:0] da;
      logic        wb;
      logic        rb;
      logic [8:0]  ab;
      logic [15:0] db;
      logic        eav;
      logic [15:0] ea;
      logic        ebv;
      logic [15:0] eb;
      logic        ecol;
   } vec_t;

   function automatic vec_t mk(input logic wa, ra, input logic [8:0] aa, input logic [15:0] da,
                               input logic wb, rb, input logic [8:0] ab, input logic [15:0] db,
                               input logic eav, input logic [15:0] ea,
                               input logic ebv, input logic [15:0] eb, input logic ecol);
      vec_t v;
      v.wa = wa; v.ra = ra; v.aa = aa; v.da = da;
      v.wb = wb; v.rb = rb; v.ab = ab; v.db = db;
      v.eav = eav; v.ea = ea; v.ebv = ebv; v.eb = eb; v.ecol = ecol;
      return v;
   endfunction

   task automatic drive_idle();
      wren_a = 0; rden_a = 0; address_a = '0; data_a = '0;
      wren_b = 0; rden_b = 0; address_b = '0; data_b = '0;
   endtask

   // Called at a negedge; the request is sampled on the next posedge (edge cyc+1).
   task automatic apply(input vec_t v);
      wren_a = v.wa; rden_a = v.ra; address_a = v.aa; data_a = v.da;
      wren_b = v.wb; rden_b = v.rb; address_b = v.ab; data_b = v.db;
      if (v.eav) begin
         exp_q[0].push_back(v.ea); due_q[0].push_back(cyc + 2);
         exp_q[2].push_back(v.ea); due_q[2].push_back(cyc + 3);
      end
      if (v.ebv) begin
         exp_q[1].push_back(v.eb); due_q[1].push_back(cyc + 2);
         exp_q[3].push_back(v.eb); due_q[3].push_back(cyc + 3);
      end
      if (v.ecol) col_q.push_back(cyc + 1);
      if (v.wa) model[v.aa] = v.da;
      if (v.wb && !(v.wa && v.aa == v.ab)) model[v.ab] = v.db;
      @(negedge clk);
   endtask

   task automatic idle_cycles(input int n);
      drive_idle();
      repeat (n) @(negedge clk);
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_out_a0"}, {16'd0, out_a0}, 32'd0);
      chk({tag, "_out_b0"}, {16'd0, out_b0}, 32'd0);
      chk({tag, "_out_a1"}, {16'd0, out_a1}, 32'd0);
      chk({tag, "_out_b1"}, {16'd0, out_b1}, 32'd0);
      chk({tag, "_valid_0"}, {30'd0, valid_a0, valid_b0}, 32'd0);
      chk({tag, "_valid_1"}, {30'd0, valid_a1, valid_b1}, 32'd0);
      chk({tag, "_coll"}, {30'd0, col0, col1}, 32'd0);
      chk({tag, "_busy"}, {30'd0, busy0, busy1}, 32'd3);
      chk({tag, "_state"}, {30'd0, st0, st1}, 32'd0);
   endtask

   // Entered at the negedge where reset is released; counts cycles with busy high.
   task automatic run_clear(input bit inject);
      int n0 = 0;
      int n1 = 0;
      while (busy0 && n0 < 2000) begin
         n0++;
         if (busy1) n1++;
         drive_idle();
         if (inject && n0 == 100) begin
            // Sweep is past address 0, so an accepted write here would survive.
            wren_a = 1; address_a = 9'd0; data_a = 16'hBEEF;
            rden_b = 1; address_b = 9'd0;
         end
         @(negedge clk);
      end
      drive_idle();
      chk("busy_cycles_0", n0, 32'd512);
      chk("busy_cycles_1", n1, 32'd512);
      chk("busy_low_1", {31'd0, busy1}, 32'd0);
      chk("state_ready", {30'd0, st0, st1}, 32'd3);
      for (int i = 0; i < 512; i++) model[i] = 16'h0000;
   endtask

   // ---------------- test ----------------
   vec_t tbl [17];

   initial begin
      vec_t v;

      tbl[0]  = mk(0, 1, 9'd0,   16'h0000, 0, 1, 9'd255, 16'h0000, 1, 16'h0000, 1, 16'h0000, 0);
      tbl[1]  = mk(0, 1, 9'd511, 16'h0000, 0, 1, 9'd0,   16'h0000, 1, 16'h0000, 1, 16'h0000, 0);
      tbl[2]  = mk(1, 0, 9'd5,   16'h1234, 0, 0, 9'd0,   16'h0000, 0, 16'h0000, 0, 16'h0000, 0);
      tbl[3]  = mk(0, 0, 9'd0,   16'h0000, 0, 1, 9'd5,   16'h0000, 0, 16'h0000, 1, 16'h1234, 0);
      tbl[4]  = mk(1, 0, 9'd9,   16'hAAAA, 1, 0, 9'd9,   16'h5555, 0, 16'h0000, 0, 16'h0000, 1);
      tbl[5]  = mk(0, 1, 9'd9,   16'h0000, 0, 1, 9'd9,   16'h0000, 1, 16'hAAAA, 1, 16'hAAAA, 0);
      tbl[6]  = mk(1, 0, 9'd3,   16'h0001, 1, 0, 9'd4,   16'h0044, 0, 16'h0000, 0, 16'h0000, 0);
      tbl[7]  = mk(1, 0, 9'd3,   16'h00FF, 0, 1, 9'd3,   16'h0000, 0, 16'h0000, 1, 16'h0001, 0);
      tbl[8]  = mk(0, 1, 9'd3,   16'h0000, 0, 1, 9'd4,   16'h0000, 1, 16'h00FF, 1, 16'h0044, 0);
      tbl[9]  = mk(1, 1, 9'd10,  16'h1111, 0, 1, 9'd10,  16'h0000, 0, 16'h0000, 1, 16'h0000, 0);
      tbl[10] = mk(0, 1, 9'd10,  16'h0000, 0, 1, 9'd10,  16'h0000, 1, 16'h1111, 1, 16'h1111, 0);
      tbl[11] = mk(0, 1, 9'd5,   16'h0000, 1, 0, 9'd511, 16'h7777, 1, 16'h1234, 0, 16'h0000, 0);
      tbl[12] = mk(0, 1, 9'd511, 16'h0000, 1, 1, 9'd12,  16'h0C0C, 1, 16'h7777, 0, 16'h0000, 0);
      tbl[13] = mk(1, 0, 9'd7,   16'h7070, 1, 0, 9'd8,   16'h8080, 0, 16'h0000, 0, 16'h0000, 0);
      tbl[14] = mk(0, 1, 9'd7,   16'h0000, 0, 1, 9'd8,   16'h0000, 1, 16'h7070, 1, 16'h8080, 0);
      tbl[15] = mk(1, 0, 9'd20,  16'h0001, 1, 0, 9'd20,  16'h0002, 0, 16'h0000, 0, 16'h0000, 1);
      tbl[16] = mk(0, 1, 9'd20,  16'h0000, 0, 1, 9'd12,  16'h0000, 1, 16'h0001, 1, 16'h0C0C, 0);

      reset = 1'b1;
      drive_idle();
      #1;
      check_reset_values("reset");
      repeat (2) @(negedge clk);
      reset = 1'b0;
      run_clear(1'b1);

      for (int i = 0; i < 17; i++) apply(tbl[i]);
      idle_cycles(4);

      // Fill 0..15 with random data, then back-to-back reads on both ports.
      for (int i = 0; i < 8; i++) begin
         v = mk(1, 0, 9'(2 * i), 16'($urandom_range(0, 65535)),
                1, 0, 9'(2 * i + 1), 16'($urandom_range(0, 65535)),
                0, 16'h0, 0, 16'h0, 0);
         apply(v);
      end
      for (int i = 0; i < 16; i++) begin
         v = mk(0, 1, 9'(i), 16'h0, 0, 1, 9'(15 - i), 16'h0,
                1, model[i], 1, model[15 - i], 0);
         apply(v);
      end
      idle_cycles(4);

      // Reset with reads still in flight.
      apply(mk(0, 1, 9'd20, 16'h0, 0, 1, 9'd3, 16'h0, 1, model[20], 1, model[3], 0));
      apply(mk(0, 1, 9'd5,  16'h0, 0, 1, 9'd7, 16'h0, 1, model[5],  1, model[7], 0));
      drive_idle();
      #2;
      reset = 1'b1;
      for (int p = 0; p < 4; p++) begin
         exp_q[p].delete();
         due_q[p].delete();
      end
      col_q.delete();
      #1;
      check_reset_values("midrst");
      repeat (3) @(negedge clk);
      reset = 1'b0;
      run_clear(1'b0);

      apply(mk(0, 1, 9'd5, 16'h0, 0, 1, 9'd9,   16'h0, 1, model[5], 1, model[9],   0));
      apply(mk(0, 1, 9'd3, 16'h0, 0, 1, 9'd511, 16'h0, 1, model[3], 1, model[511], 0));
      idle_cycles(5);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/dpram_param.md
# dpram_param

Parametrised dual-port RAM for the attention-layer output and buffer memories, replacing the fixed 16-bit × 512 output RAM. Both ports are symmetric. Each port has explicit read enables, a read-valid flag and an optional output register stage. The block adds write-write collision arbitration and a post-reset clear sequencer that zeroes the whole array before accepting traffic. It sits between the softmax/accumulate stages and the output-BRAM readers.

## Interface
- DATA_WIDTH, 16: word width in bits.
- ADDR_WIDTH, 9: address width; DEPTH = 2**ADDR_WIDTH (default 512).
- OUT_REG, 0: 1 adds an output register; read latency is 1 + OUT_REG.
- CLEAR_ON_RESET, 1: 1 runs the zero-fill sweep after reset.
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- address_a / address_b  in  ADDR_WIDTH  port A/B address.
- wren_a / wren_b  in  1  write enable.
- rden_a / rden_b  in  1  read enable; ignored when the same port's wren is high.
- data_a / data_b  in  DATA_WIDTH  write data.
- out_a / out_b  out  DATA_WIDTH  read data; holds its last value between reads.
- valid_a / valid_b  out  1  one-cycle pulse aligned with new out_x data.
- busy  out  1  high while the clear sweep runs; all requests are ignored while busy is high.
- collision  out  1  one-cycle pulse, registered, the cycle after a same-address double write.

## Operation
- FSM states: CLEAR, READY.
- Reset asserted: state = CLEAR if CLEAR_ON_RESET, else READY. Clear counter = 0. Pipeline valids dropped. Memory contents are not touched by reset itself.
- CLEAR: writes 0 to address cnt each cycle, then cnt++. After writing DEPTH-1, state goes to READY. busy = (state == CLEAR).
- READY, per port x:
  - wren_x: ram[address_x] <= data_x. No read occurs; out_x holds and valid_x stays 0.
  - rden_x with !wren_x: read ram[address_x]; valid_x pulses with the data.
  - Neither enable: idle.
- Write-write, same address: port A's data is stored, port B's write is dropped, collision pulses.
- Write-write, different addresses: both writes are stored.
- Read on one port with a write to the same address on the other port: the read returns the old (pre-write) data. No collision pulse.
- Both ports reading the same address: both return the same data.
- Address wrap: addresses are modulo DEPTH. No out-of-range case exists.

## Timing
- Reset values: out_a = out_b = 0, valid_a = valid_b = 0, collision = 0. busy = 1 if CLEAR_ON_RESET, else 0.
- Clear duration: busy falls exactly DEPTH cycles after the first rising edge with reset low (512 cycles at default). The first request is accepted in the cycle busy is low.
- Read latency: the request on edge N gives out_x/valid_x after edge N+1 (OUT_REG=0) or N+2 (OUT_REG=1).
- Throughput: one operation per port per cycle, back-to-back, no bubbles.
- Writes are visible to a read issued on the next edge or later.
- Reset mid-operation: in-flight reads are discarded with no valid pulse. Outputs return to reset values immediately (asynchronously). The clear sweep restarts from address 0.
- A request presented during busy is dropped silently. It is not queued.

## Structure
- Shared package attn_mem_pkg holds:
  - default DATA_WIDTH (16) and OUT_RAM_DEPTH (512) constants;
  - the CLEAR/READY state encoding;
  - the latency helper constant (1 + OUT_REG).
- One sub-module, dpram_core: a bare DEPTH × DATA_WIDTH array with two synchronous ports (we, addr, din, dout) and no reset. It infers a true dual-port BRAM.
- The wrapper owns:
  - the FSM and clear counter (the clear drives port A of the core);
  - collision arbitration, which gates port B's write enable;
  - the enable-to-valid pipeline;
  - the optional output register.

## Test plan
- Reset with CLEAR_ON_RESET=1, DEPTH=512 → busy high for exactly 512 cycles. Afterwards, reading addresses 0, 255 and 511 returns 0x0000 with valid pulses.
- After the clear: write 0x1234 to address 5 on port A, then the next cycle read address 5 on port B → out_b = 0x1234, valid_b pulses 1 cycle later with OUT_REG=0 and 2 cycles later with OUT_REG=1.
- Same cycle: A writes 0xAAAA and B writes 0x5555, both to address 9 → collision pulses once. A later read of address 9 returns 0xAAAA.
- Address 3 holds 0x0001. A writes 0x00FF to address 3 while B reads address 3 in the same cycle → out_b = 0x0001. A read of address 3 on the next cycle gives 0x00FF.
- Back-to-back reads of addresses 0..15 on both ports with OUT_REG=1 → 16 consecutive valid pulses per port with correct data and no gaps.
- Reset asserted with two reads in flight → no valid pulses, outputs immediately 0, busy high again, sweep restarts from address 0.
